// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI frame sequencer: FSM states, frame layout, channel width.
package spi_seq_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

    localparam int unsigned NUM_SLAVES_DEF = 5;
    localparam int unsigned NUM_BITS_DEF   = 12;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W = ch_width(NUM_SLAVES_DEF);

    // Same layout as the SPI parallel frame: channel i at [i].
    typedef logic [NUM_SLAVES_DEF-1:0][NUM_BITS_DEF-1:0] frame_t;

endpackage

// File: rtl/sample_timer.sv
// Sample period down-counter: one-cycle trigger every period_i cycles while enabled.
module sample_timer #(
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    trigger_o
);

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic [PERIOD_WIDTH-1:0] reload;

    // Periods of 0 and 1 both reload 0, i.e. trigger every cycle.
    assign reload    = (period_i > PERIOD_WIDTH'(1)) ? period_i - PERIOD_WIDTH'(1) : '0;
    assign trigger_o = enable_i && run_q && (cnt_q == '0);

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (!enable_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (!run_q || trigger_o) begin
            run_d = 1'b1;
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Triggers SPI conversions on a sample period, captures each parallel frame and streams
// it out one channel per valid/ready handshake; flags overruns and conversion timeouts.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_SLAVES      = NUM_SLAVES_DEF,
    parameter int unsigned NUM_BITS        = NUM_BITS_DEF,
    parameter int unsigned PERIOD_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned FRAME_CNT_WIDTH = 16,
    localparam int unsigned CH_BITS        = ch_width(NUM_SLAVES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [PERIOD_WIDTH-1:0]        samplePeriod,
    output logic                           spiStart,
    input  logic                           spiValid,
    input  logic [NUM_SLAVES*NUM_BITS-1:0] spiData,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [NUM_BITS-1:0]            outData,
    output logic [CH_BITS-1:0]             outChannel,
    output logic                           outLast,
    output logic [FRAME_CNT_WIDTH-1:0]     frameCount,
    output logic                           overrun,
    output logic                           timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_SLAVES - 1);

    state_t                               state_q, state_d;
    logic [NUM_SLAVES-1:0][NUM_BITS-1:0]  frame_q, frame_d;
    logic [TO_W-1:0]                      to_cnt_q, to_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0]           frame_cnt_q, frame_cnt_d;
    logic [NUM_BITS-1:0]                  out_data_q, out_data_d;
    logic [CH_BITS-1:0]                   out_ch_q, out_ch_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 out_last_q, out_last_d;
    logic                                 spi_start_q, spi_start_d;
    logic                                 spi_valid_q;
    logic                                 overrun_q, overrun_d;
    logic                                 timeout_q, timeout_d;
    logic                                 trigger;
    logic                                 spi_valid_rise;

    sample_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_sample_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .enable_i (enable),
        .period_i (samplePeriod),
        .trigger_o(trigger)
    );

    assign spi_valid_rise = spiValid && !spi_valid_q;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        to_cnt_d    = to_cnt_q;
        frame_cnt_d = frame_cnt_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        spi_start_d = 1'b0;
        timeout_d   = timeout_q;
        // Triggers outside IDLE (including the DRAIN->IDLE cycle) are dropped, not queued.
        overrun_d   = overrun_q | (trigger && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d     = START;
                    spi_start_d = 1'b1;
                end
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (spi_valid_rise) begin
                    frame_d     = spiData;
                    out_valid_d = 1'b1;
                    out_data_d  = spiData[NUM_BITS-1:0];
                    out_ch_d    = '0;
                    out_last_d  = (NUM_SLAVES == 1);
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                    state_d     = DRAIN;
                end else if (to_cnt_q == TO_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DRAIN: begin
                if (outReady) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_ch_d   = out_ch_q + CH_BITS'(1);
                        out_data_d = frame_q[out_ch_d];
                        out_last_d = (out_ch_d == LAST_CH);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            to_cnt_q    <= '0;
            frame_cnt_q <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            spi_start_q <= 1'b0;
            spi_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            to_cnt_q    <= to_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            spi_start_q <= spi_start_d;
            spi_valid_q <= spiValid;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign spiStart   = spi_start_q;
    assign outValid   = out_valid_q;
    assign outData    = out_data_q;
    assign outChannel = out_ch_q;
    assign outLast    = out_last_q;
    assign frameCount = frame_cnt_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed self-checking bench for spi_frame_sequencer with a latency-programmable SPI model.
module tb_spi_frame_sequencer;
    import spi_seq_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   samplePeriod;
    logic          spiStart;
    logic          spiValid;
    logic [59:0]   spiData;
    logic          outValid;
    logic          outReady;
    logic [11:0]   outData;
    logic [CH_W-1:0] outChannel;
    logic          outLast;
    logic [3:0]    frameCount;
    logic          overrun;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // SPI model state: responds spi_lat cycles after spiStart, holds spiValid for 3 cycles.
    bit     model_en = 1'b1;
    int     spi_lat = 40;
    int     spi_base = 'h100;
    int     pend = 0;
    int     hold_cnt = 0;
    logic   mdl_valid = 1'b0;
    frame_t mdl_data = '0;
    logic   man_valid = 1'b0;
    frame_t man_data = '0;

    // Observations of one drained frame.
    int            obs_n, obs_first, obs_unstable;
    logic [11:0]   obs_data [0:7];
    logic [CH_W-1:0] obs_ch [0:7];
    logic          obs_last [0:7];

    assign spiValid = model_en ? mdl_valid : man_valid;
    assign spiData  = model_en ? mdl_data  : man_data;

    spi_frame_sequencer #(
        .NUM_SLAVES     (5),
        .NUM_BITS       (12),
        .PERIOD_WIDTH   (16),
        .TIMEOUT_CYCLES (1024),
        .FRAME_CNT_WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .samplePeriod(samplePeriod),
        .spiStart    (spiStart),
        .spiValid    (spiValid),
        .spiData     (spiData),
        .outValid    (outValid),
        .outReady    (outReady),
        .outData     (outData),
        .outChannel  (outChannel),
        .outLast     (outLast),
        .frameCount  (frameCount),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t mk_frame(input int base);
        frame_t r;
        for (int i = 0; i < 5; i++) r[i] = 12'(base + i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (model_en) begin
            if (hold_cnt > 0) begin
                hold_cnt = hold_cnt - 1;
                if (hold_cnt == 0) mdl_valid = 1'b0;
            end
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    mdl_valid = 1'b1;
                    mdl_data  = mk_frame(spi_base);
                    hold_cnt  = 3;
                end
            end
            if (spiStart && spi_lat > 0) pend = spi_lat;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        outReady = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Returns the cycle stamp of the next spiStart, or -1 if none within bound.
    task automatic wait_start(input int bound, output int found);
        found = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (spiStart) begin
                found = cyc;
                break;
            end
        end
    endtask

    // Drains one frame; mode 0 = always ready, mode 1 = ready 1 cycle in 3.
    task automatic capture_words(input int mode, input int bound);
        bit          stalled = 1'b0;
        bit          rdy;
        logic [11:0] held_d = '0;
        logic [CH_W-1:0] held_c = '0;
        obs_n = 0;
        obs_first = -1;
        obs_unstable = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (stalled && (!outValid || outData !== held_d || outChannel !== held_c))
                obs_unstable++;
            stalled = 1'b0;
            if (outValid && obs_first < 0) obs_first = cyc;
            rdy = (mode == 0) || (k % 3 == 0);
            outReady = rdy;
            if (outValid) begin
                if (rdy) begin
                    if (obs_n < 8) begin
                        obs_data[obs_n] = outData;
                        obs_ch[obs_n]   = outChannel;
                        obs_last[obs_n] = outLast;
                    end
                    obs_n++;
                    if (outLast) break;
                end else begin
                    stalled = 1'b1;
                    held_d  = outData;
                    held_c  = outChannel;
                end
            end
        end
        outReady = 1'b1;
    endtask

    task automatic test_reset();
        int starts = 0;
        n_cmp++;
        if ({spiStart, outValid, outLast, overrun, timeout, frameCount, outData, outChannel}
            !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {spiStart, outValid, outLast, overrun, timeout, frameCount, outData,
                      outChannel});
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spiStart) starts++;
        end
        n_cmp++;
        if (starts != 0) begin
            n_err++;
            $display("FAIL disabled_no_start: got %0d starts required 0", starts);
        end
    endtask

    task automatic test_periodic();
        int c0, s1, s2;
        samplePeriod = 16'd100;
        spi_base = 'h100;
        spi_lat = 40;
        enable = 1'b1;
        c0 = cyc;
        wait_start(300, s1);
        n_cmp++;
        if (s1 != c0 + 101) begin
            n_err++;
            $display("FAIL first_start: got cycle %0d required %0d", s1, c0 + 101);
        end
        capture_words(0, 200);
        n_cmp++;
        if (obs_first != s1 + 41) begin
            n_err++;
            $display("FAIL capture_latency: got cycle %0d required %0d", obs_first, s1 + 41);
        end
        n_cmp++;
        if (obs_n != 5) begin
            n_err++;
            $display("FAIL word_count: got %0d required 5", obs_n);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs_data[i] !== 12'('h100 + i) || obs_ch[i] !== CH_W'(i)
                || obs_last[i] !== (i == 4)) begin
                n_err++;
                $display("FAIL word%0d: got data %0h ch %0d last %0b required %0h %0d %0b",
                         i, obs_data[i], obs_ch[i], obs_last[i], 'h100 + i, i, i == 4);
            end
        end
        n_cmp++;
        if (frameCount !== 4'd1) begin
            n_err++;
            $display("FAIL frame_count_1: got %0d required 1", frameCount);
        end
        wait_start(200, s2);
        n_cmp++;
        if (s2 - s1 != 100) begin
            n_err++;
            $display("FAIL start_period: got %0d required 100", s2 - s1);
        end
        capture_words(0, 200);
        n_cmp++;
        if (frameCount !== 4'd2 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL frame2: got count %0d overrun %0b required 2 0", frameCount, overrun);
        end
    endtask

    task automatic test_backpressure();
        int s;
        do_reset();
        samplePeriod = 16'd100;
        spi_base = 'h200;
        enable = 1'b1;
        wait_start(300, s);
        capture_words(1, 400);
        n_cmp++;
        if (obs_n != 5 || obs_unstable != 0) begin
            n_err++;
            $display("FAIL bp_words: got %0d words %0d unstable required 5 0",
                     obs_n, obs_unstable);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs_data[i] !== 12'('h200 + i) || obs_ch[i] !== CH_W'(i)) begin
                n_err++;
                $display("FAIL bp_word%0d: got data %0h ch %0d required %0h %0d",
                         i, obs_data[i], obs_ch[i], 'h200 + i, i);
            end
        end
        n_cmp++;
        if (frameCount !== 4'd1) begin
            n_err++;
            $display("FAIL bp_frame_count: got %0d required 1", frameCount);
        end
    endtask

    task automatic test_overrun();
        int c0, s1, s2, s3;
        do_reset();
        samplePeriod = 16'd30;
        spi_lat = 40;
        enable = 1'b1;
        c0 = cyc;
        wait_start(100, s1);
        n_cmp++;
        if (s1 != c0 + 31) begin
            n_err++;
            $display("FAIL ovr_first_start: got cycle %0d required %0d", s1, c0 + 31);
        end
        repeat (29) @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_before: got %0b required 0", overrun);
        end
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set: got %0b required 1", overrun);
        end
        wait_start(100, s2);
        wait_start(100, s3);
        n_cmp++;
        if (s2 - s1 != 60 || s3 - s2 != 60) begin
            n_err++;
            $display("FAIL ovr_start_rate: got %0d %0d required 60 60", s2 - s1, s3 - s2);
        end
        n_cmp++;
        if (frameCount !== 4'd2) begin
            n_err++;
            $display("FAIL ovr_frames: got %0d required 2", frameCount);
        end
    endtask

    task automatic test_timeout();
        int s, s2;
        int valids = 0;
        do_reset();
        samplePeriod = 16'd1100;
        spi_lat = 0;
        enable = 1'b1;
        wait_start(1300, s);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (outValid) valids++;
        end
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got %0b required 0", timeout);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set: got %0b required 1", timeout);
        end
        n_cmp++;
        if (valids != 0) begin
            n_err++;
            $display("FAIL timeout_no_output: got %0d valid cycles required 0", valids);
        end
        spi_lat = 40;
        wait_start(200, s2);
        n_cmp++;
        if (s2 != s + 1100 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_restart: got cycle %0d overrun %0b required %0d 0",
                     s2, overrun, s + 1100);
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 1'b0;
        int c0, s;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outValid && outChannel == CH_W'(2)) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit || frameCount !== 4'd1 || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL mr_pre: got hit %0b count %0d timeout %0b required 1 1 1",
                     hit, frameCount, timeout);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({outValid, frameCount, timeout, overrun, outChannel, outData} !== '0) begin
            n_err++;
            $display("FAIL mr_async_clear: got valid %0b count %0d to %0b ovr %0b ch %0d d %0h",
                     outValid, frameCount, timeout, overrun, outChannel, outData);
        end
        samplePeriod = 16'd100;
        @(negedge clk);
        rst = 1'b1;
        c0 = cyc;
        wait_start(300, s);
        n_cmp++;
        if (s != c0 + 101) begin
            n_err++;
            $display("FAIL mr_first_start: got cycle %0d required %0d", s, c0 + 101);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        samplePeriod = 16'd20;
        spi_lat = 5;
        enable = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            capture_words(0, 100);
            n_cmp++;
            if (frameCount !== 4'(f)) begin
                n_err++;
                $display("FAIL wrap_frame%0d: got %0d required %0d", f, frameCount, f % 16);
            end
        end
    endtask

    task automatic test_edge_once();
        int s, s2;
        int valids = 0;
        do_reset();
        model_en = 1'b0;
        man_valid = 1'b0;
        samplePeriod = 16'd50;
        enable = 1'b1;
        wait_start(100, s);
        @(negedge clk);
        man_valid = 1'b1;
        man_data = mk_frame('h300);
        capture_words(0, 20);
        n_cmp++;
        if (obs_n != 5 || obs_data[4] !== 12'h304 || frameCount !== 4'd1) begin
            n_err++;
            $display("FAIL edge_first: got %0d words d4 %0h count %0d required 5 304 1",
                     obs_n, obs_data[4], frameCount);
        end
        wait_start(100, s2);
        n_cmp++;
        if (s2 != s + 50) begin
            n_err++;
            $display("FAIL edge_second_start: got cycle %0d required %0d", s2, s + 50);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (outValid) valids++;
        end
        n_cmp++;
        if (valids != 0 || frameCount !== 4'd1) begin
            n_err++;
            $display("FAIL edge_level_held: got %0d valid cycles count %0d required 0 1",
                     valids, frameCount);
        end
        man_valid = 1'b0;
        @(negedge clk);
        man_valid = 1'b1;
        man_data = mk_frame('h400);
        capture_words(0, 20);
        n_cmp++;
        if (obs_data[0] !== 12'h400 || frameCount !== 4'd2) begin
            n_err++;
            $display("FAIL edge_new_rise: got d0 %0h count %0d required 400 2",
                     obs_data[0], frameCount);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        samplePeriod = '0;
        outReady = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_backpressure();
        test_overrun();
        test_timeout();
        test_mid_reset();
        test_wrap();
        test_edge_once();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
